// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_fetch_ctrl : issues one SRAM-like instruction request per fetch PC and
//                 delivers the returned word to decode. Stale responses are
//                 discarded after a redirect.
// Optional misaligned-fetch check: define FETCH_ADEL_CHECK_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        flushF,
  input  logic        stallD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instF,
  output logic [31:0] pc_instF,
  output logic        inst_validF,
  output logic        i_stall,
  output logic        adelF
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic        hold_adel, hold_adel_n;
  logic        drop_pend, drop_pend_n;

  logic        misaligned;
  logic        req_c, valid_c, adel_c;
  logic [31:0] addr_c, inst_c, pc_c;

  // The reset PC is owned by the PC register; it is carried here for reference.
  logic unused_reset_pc;
  assign unused_reset_pc = ^RESET_PC;

`ifdef FETCH_ADEL_CHECK_EN
  assign misaligned = (pcF[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_pc    <= 32'd0;
      hold_inst <= 32'd0;
      hold_adel <= 1'b0;
      drop_pend <= 1'b0;
    end else begin
      state     <= state_n;
      req_pc    <= req_pc_n;
      hold_inst <= hold_inst_n;
      hold_adel <= hold_adel_n;
      drop_pend <= drop_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    req_pc_n    = req_pc;
    hold_inst_n = hold_inst;
    hold_adel_n = hold_adel;
    drop_pend_n = drop_pend;
    req_c       = 1'b0;
    addr_c      = req_pc;
    valid_c     = 1'b0;
    inst_c      = 32'd0;
    pc_c        = req_pc;
    adel_c      = 1'b0;

    case (state)
      S_IDLE: begin
        addr_c = pcF;
        if (!flushF) begin
          if (misaligned) begin
            // Fault is reported in place of a bus fetch.
            valid_c = 1'b1;
            pc_c    = pcF;
            adel_c  = 1'b1;
            if (stallD) begin
              state_n     = S_HOLD;
              hold_inst_n = 32'd0;
              hold_adel_n = 1'b1;
              req_pc_n    = pcF;
            end
          end else begin
            req_c    = 1'b1;
            req_pc_n = pcF;
            state_n  = inst_addr_ok ? S_WAIT : S_REQ;
          end
        end
      end
      S_REQ: begin
        req_c = 1'b1;
        if (inst_addr_ok) begin
          state_n     = (flushF || drop_pend) ? S_DROP : S_WAIT;
          drop_pend_n = 1'b0;
        end else if (flushF) begin
          drop_pend_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (flushF) begin
            state_n = S_IDLE;
          end else begin
            valid_c = 1'b1;
            inst_c  = inst_rdata;
            if (stallD) begin
              state_n     = S_HOLD;
              hold_inst_n = inst_rdata;
              hold_adel_n = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end
        end else if (flushF) begin
          state_n = S_DROP;
        end
      end
      S_HOLD: begin
        valid_c = !flushF;
        inst_c  = hold_inst;
        adel_c  = hold_adel;
        if (flushF || !stallD) state_n = S_IDLE;
      end
      S_DROP: begin
        if (inst_data_ok) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign inst_req    = req_c & ~rst;
  assign inst_addr   = addr_c;
  assign inst_validF = valid_c & ~rst;
  assign instF       = inst_validF ? inst_c : 32'd0;
  assign pc_instF    = pc_c;
  assign adelF       = inst_validF & adel_c;
  // A redirect must always be able to load the PC, so flush releases the stall.
  assign i_stall     = ~inst_validF & ~(flushF & ~rst);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl : directed and randomized checks of if_fetch_ctrl against a
//                    transaction-level reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
`ifdef FETCH_ADEL_CHECK_EN
  localparam bit ADEL_EN = 1'b1;
`else
  localparam bit ADEL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcF = RESET_PC;
  logic        flushF = 1'b0, stallD = 1'b0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        inst_req, inst_validF, i_stall, adelF;
  logic [31:0] inst_addr, instF, pc_instF;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .flushF(flushF), .stallD(stallD),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .instF(instF),
    .pc_instF(pc_instF), .inst_validF(inst_validF), .i_stall(i_stall), .adelF(adelF)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp_v, $time);
  endtask

  // Reference model: open request, in-flight transaction, held word.
  bit          m_req_open = 0, m_req_stale = 0;
  bit          m_fly = 0, m_fly_stale = 0;
  bit          m_held = 0, m_held_adel = 0;
  logic [31:0] m_req_addr = 0, m_fly_pc = 0, m_held_word = 0, m_held_pc = 0;
  bit          bus_busy = 0;

  bit          e_req, e_valid, e_adel, e_stall;
  logic [31:0] e_addr, e_inst, e_pc;

  logic [31:0] pc_reg = RESET_PC;
  logic [31:0] flush_tgt = 0;

  function automatic bit is_mis();
    return ADEL_EN && (pcF[1:0] != 2'b00);
  endfunction

  function automatic void model_out();
    e_req = 0; e_addr = 0; e_valid = 0; e_inst = 0; e_pc = 0; e_adel = 0;
    if (rst) begin
    end else if (m_held) begin
      e_valid = !flushF; e_inst = m_held_word; e_pc = m_held_pc; e_adel = m_held_adel;
    end else if (m_req_open) begin
      e_req = 1; e_addr = m_req_addr;
    end else if (m_fly) begin
      if (inst_data_ok && !m_fly_stale && !flushF) begin
        e_valid = 1; e_inst = inst_rdata; e_pc = m_fly_pc;
      end
    end else if (!flushF) begin
      if (is_mis()) begin
        e_valid = 1; e_pc = pcF; e_adel = 1;
      end else begin
        e_req = 1; e_addr = pcF;
      end
    end
    e_stall = !e_valid && !(flushF && !rst);
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_req_open = 0; m_req_stale = 0; m_fly = 0; m_fly_stale = 0;
      m_held = 0; m_held_adel = 0; bus_busy = 0;
      return;
    end
    if (inst_data_ok) bus_busy = 0;
    if (inst_addr_ok && e_req) bus_busy = 1;
    if (m_held) begin
      if (flushF || !stallD) m_held = 0;
    end else if (m_req_open) begin
      if (inst_addr_ok) begin
        m_req_open = 0; m_fly = 1; m_fly_stale = m_req_stale | flushF; m_fly_pc = m_req_addr;
      end else if (flushF) begin
        m_req_stale = 1;
      end
    end else if (m_fly) begin
      if (inst_data_ok) begin
        m_fly = 0;
        if (!m_fly_stale && !flushF && stallD) begin
          m_held = 1; m_held_word = inst_rdata; m_held_adel = 0; m_held_pc = m_fly_pc;
        end
      end else if (flushF) begin
        m_fly_stale = 1;
      end
    end else if (!flushF) begin
      if (is_mis()) begin
        if (stallD) begin
          m_held = 1; m_held_word = 0; m_held_adel = 1; m_held_pc = pcF;
        end
      end else if (inst_addr_ok) begin
        m_fly = 1; m_fly_stale = 0; m_fly_pc = pcF;
      end else begin
        m_req_open = 1; m_req_addr = pcF; m_req_stale = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    check("inst_req", inst_req, e_req);
    check("i_stall", i_stall, e_stall);
    check("inst_validF", inst_validF, e_valid);
    if (e_req) check("inst_addr", inst_addr, e_addr);
    if (e_valid) begin
      check("instF", instF, e_inst);
      check("pc_instF", pc_instF, e_pc);
      check("adelF", adelF, e_adel);
    end
    if (rst) begin
      check("instF_rst", instF, 32'd0);
      check("adelF_rst", adelF, 32'd0);
    end
  endtask

  // Apply inputs (called just after a falling edge), settle, compare to model.
  task automatic drive(input bit r, input logic [31:0] pc, input bit fl, input bit st,
                       input bit aok, input bit dok, input logic [31:0] rd);
    rst = r; pcF = pc; flushF = fl; stallD = st;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    #1;
    model_out();
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    rst          = ($urandom_range(0, 199) == 0);
    pcF          = pc_reg;
    flushF       = ($urandom_range(0, 9) == 0);
    stallD       = ($urandom_range(0, 3) == 0);
    inst_data_ok = bus_busy && ($urandom_range(0, 2) != 0);
    inst_rdata   = $urandom;
    flush_tgt    = $urandom;
    if ($urandom_range(0, 3) != 0) flush_tgt[1:0] = 2'b00;
    inst_addr_ok = 1'b0;
    model_out();
    inst_addr_ok = e_req && ($urandom_range(0, 2) != 0);
    #1;
    model_out();
    check_outputs();
    advance();
    if (rst) pc_reg = RESET_PC;
    else if (flushF) pc_reg = flush_tgt;
    else if (!(e_stall || stallD)) pc_reg = pc_reg + 32'd4;
  endtask

  initial begin
    // Reset
    drive(1, RESET_PC, 0, 0, 0, 0, 0);
    check("rst_req", inst_req, 0);
    check("rst_stall", i_stall, 1);
    @(negedge clk);
    drive(1, RESET_PC, 1, 1, 0, 0, 0);
    check("rst_valid", inst_validF, 0);
    advance();

    // Best case: accepted immediately, data next cycle
    drive(0, 32'hbfc0_0000, 0, 0, 1, 0, 0);
    check("bc_req", inst_req, 1);
    check("bc_addr", inst_addr, 32'hbfc0_0000);
    advance();
    drive(0, 32'hbfc0_0000, 0, 0, 0, 1, 32'h2408_0001);
    check("bc_valid", inst_validF, 1);
    check("bc_inst", instF, 32'h2408_0001);
    check("bc_stall", i_stall, 0);
    advance();

    // addr_ok delayed three cycles
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'hbfc0_0004, 0, 0, (i == 3), 0, 0);
      check("dly_req", inst_req, 1);
      check("dly_addr", inst_addr, 32'hbfc0_0004);
      check("dly_stall", i_stall, 1);
      advance();
    end

    // Decode stalled when data returns: word held until stallD drops
    drive(0, 32'hbfc0_0004, 0, 1, 0, 1, 32'h8C01_0004);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'hbfc0_0004, 0, (i != 3), 0, 0, 32'hdead_beef);
      check("hold_valid", inst_validF, 1);
      check("hold_inst", instF, 32'h8C01_0004);
      check("hold_req", inst_req, 0);
      advance();
    end

    // Flush while waiting; stale data two cycles later is dropped
    drive(0, 32'hbfc0_0008, 0, 0, 1, 0, 0);
    advance();
    drive(0, 32'hbfc0_0008, 1, 0, 0, 0, 0);
    advance();
    drive(0, 32'hbfc0_0380, 0, 0, 0, 0, 0);
    advance();
    drive(0, 32'hbfc0_0380, 0, 0, 0, 1, 32'h1111_2222);
    check("wflush_valid", inst_validF, 0);
    advance();
    drive(0, 32'hbfc0_0380, 0, 0, 0, 0, 0);
    check("wflush_addr", inst_addr, 32'hbfc0_0380);
    advance();

    // Flush while request pending: accepted later, response dropped
    drive(0, 32'hbfc0_0380, 1, 0, 0, 0, 0);
    advance();
    drive(0, 32'hbfc0_0400, 0, 0, 1, 0, 0);
    check("rflush_addr", inst_addr, 32'hbfc0_0380);
    advance();
    drive(0, 32'hbfc0_0400, 0, 0, 0, 1, 32'h3333_4444);
    check("rflush_valid", inst_validF, 0);
    advance();
    drive(0, 32'hbfc0_0400, 0, 0, 1, 0, 0);
    check("rflush_next", inst_addr, 32'hbfc0_0400);
    advance();
    drive(0, 32'hbfc0_0400, 0, 0, 0, 1, 32'h5555_6666);
    check("rflush_inst", instF, 32'h5555_6666);
    advance();

    // Misaligned fetch
`ifdef FETCH_ADEL_CHECK_EN
    drive(0, 32'hbfc0_0002, 0, 0, 0, 0, 0);
    check("adel_req", inst_req, 0);
    check("adel_valid", inst_validF, 1);
    check("adel_flag", adelF, 1);
    check("adel_inst", instF, 32'd0);
    check("adel_pc", pc_instF, 32'hbfc0_0002);
    advance();
`else
    drive(0, 32'hbfc0_0002, 0, 0, 1, 0, 0);
    check("mis_addr", inst_addr, 32'hbfc0_0002);
    advance();
    drive(0, 32'hbfc0_0002, 0, 0, 0, 1, 32'h7777_8888);
    check("mis_adel", adelF, 0);
    advance();
`endif

    // Randomized traffic
    pc_reg = 32'hbfc0_1000;
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
